apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB completer that sits directly downstream of the APB interface bundle and consumes psel/penable/paddr/pwrite/pwdata.
- Returns prdata/pready/pslverr from a bank of 32-bit registers.
- Wait states are configurable; per-register read-only protection is supported.
- Serves as the DUT-side responder for the APB UVC and as a reusable CSR block.

Parameters:
- NUM_REGS, 16, number of 32-bit registers (1..256).
- BASE_ADDR, 32'h0000_0000, byte address of register 0.
- WAIT_STATES, 0, extra ACCESS cycles before pready (0..15).
- RO_MASK, 16'h0000 (width NUM_REGS), bit i=1 makes register i read-only.
- RESET_VAL, 32'h0000_0000, reset value of every register.

Ports:
- clk  input  1  system clock, all logic on posedge.
- resetn  input  1  synchronous active-low reset.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- paddr  input  32  APB byte address.
- pwrite  input  1  1=write, 0=read.
- pwdata  input  32  write data.
- prdata  output  32  read data, valid when pready=1 and pwrite=0.
- pready  output  1  transfer-complete strobe.
- pslverr  output  1  error response, valid only with pready=1.

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-low (resetn).
- Reset (resetn=0 at posedge):
  - state=IDLE, wait_cnt=0, prdata=0, pready=0, pslverr=0.
  - All registers load RESET_VAL.
  - No output is ever X/Z after the first reset edge.
- Outputs are registered: pready, pslverr and prdata are all flops.
- Decode:
  - offset = paddr - BASE_ADDR; idx = offset[9:2].
  - addr_err = (paddr[1:0]!=0) or (paddr < BASE_ADDR) or (offset >= NUM_REGS*4).
  - ro_err = pwrite && !addr_err && RO_MASK[idx].
  - err = addr_err | ro_err.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel=1 && penable=0 (setup), latch paddr/pwrite/pwdata and err, then go to ACCESS.
  - wait_cnt <= WAIT_STATES.
  - If WAIT_STATES==0: pready<=1, pslverr<=err, prdata<=read data (0 if write or err).
  - psel=1 && penable=1 while in IDLE is a protocol error: ignored, no response.
- ACCESS:
  - If pready==1, the transfer completes this cycle:
    - Write commits at this edge if pwrite && !err.
    - Next state IDLE; pready<=0, pslverr<=0, prdata<=0.
  - Else if wait_cnt==1: pready<=1, pslverr<=err, prdata loaded; wait_cnt<=0.
  - Else wait_cnt decrements.
  - If psel drops in ACCESS before completion: abort to IDLE, no write, outputs cleared.
- Latency: total transfer is 2+WAIT_STATES cycles (setup plus ACCESS cycles).
- Back-to-back: a new setup may appear in the cycle after completion, because IDLE accepts it immediately, so there are no dead cycles.
- Errored or read-only writes leave register contents unchanged; reads of read-only registers succeed.
- Latched address/data are used for the whole transfer; paddr/pwdata changes during ACCESS are ignored.
- Reset mid-transfer: the transfer is dropped, no write occurs, and all outputs go to their reset values on that edge.

Decomposition:
- apb_pkg holds:
  - APB_ADDR_W=32, APB_DATA_W=32.
  - apb_state_e {IDLE, ACCESS}.
  - Function apb_decode(paddr, base, num_regs) returning idx and addr_err.
- Sub-module apb_reg_bank holds the register array:
  - Inputs: wr_en, wr_idx, wr_data.
  - Combinational read on rd_idx.
  - Applies RESET_VAL on synchronous reset.
- apb_slave_regfile keeps the FSM, wait counter, decode and output flops.

Test Plan:
- Reset and X-checks: hold resetn=0 for 3 cycles, then release → prdata=0, pready=0, pslverr=0; the interface X/Z checks never fire.
- Zero-wait write/read, WAIT_STATES=0: write 32'hDEAD_BEEF to 0x08, then read 0x08 → pready high in the 2nd cycle of each transfer, prdata=32'hDEAD_BEEF, pslverr=0.
- Wait states, WAIT_STATES=3: read 0x04 → pready rises exactly 4 cycles after the setup cycle, 5-cycle transfer, pready=1 for one cycle only.
- Errors: read 0x40 with NUM_REGS=16, misaligned write to 0x06, and write to a read-only register (RO_MASK=16'h0001, addr 0x00) → pslverr=1 with pready; a subsequent read of 0x00 returns RESET_VAL.
- Back-to-back: 4 consecutive writes to 0x00..0x0C with no idle cycle, then 4 reads → each read returns its written value, and each transfer takes 2 cycles.
- Abort and reset: WAIT_STATES=2, write 32'h1234 to 0x10, drop psel (or assert resetn=0) during the first wait cycle → no pready, and a read of 0x10 returns its previous value (RESET_VAL after reset).

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB widths, FSM state type and the address decode helper
// used by the register-file completer.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   typedef struct packed {
      logic [7:0] idx;
      logic       addr_err;
   } apb_dec_t;

   // Word index plus range/alignment error for a byte address.
   function automatic apb_dec_t apb_decode(input logic [APB_ADDR_W-1:0] paddr,
                                           input logic [APB_ADDR_W-1:0] base,
                                           input int unsigned           num_regs);
      logic [APB_ADDR_W-1:0] offset;
      apb_dec_t              d;
      offset     = paddr - base;
      d.idx      = offset[9:2];
      d.addr_err = (paddr[1:0] != 2'b00) || (paddr < base) || (offset >= num_regs * 4);
      return d;
   endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Array of 32-bit CSRs: one synchronous write port, one combinational read port.
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int                    NUM_REGS  = 16,
   parameter logic [APB_DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wr_en,
   input  logic [7:0]            wr_idx,
   input  logic [APB_DATA_W-1:0] wr_data,
   input  logic [7:0]            rd_idx,
   output logic [APB_DATA_W-1:0] rd_data
);

   logic [APB_DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == 8'(i)) regs[i] <= wr_data;
         end
      end
   end

   // Compare-based select keeps out-of-range indices harmless (reads as 0).
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == 8'(i)) rd_data = regs[i];
      end
   end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer in front of a CSR bank: configurable wait states,
// per-register read-only protection, fully registered response.
//
// state  | meaning
// IDLE   | waiting for a setup phase (psel=1, penable=0)
// ACCESS | transfer latched; counting wait states, then presenting pready
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int                    NUM_REGS    = 16,
   parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int                    WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
   parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic [APB_ADDR_W-1:0] paddr,
   input  logic                  pwrite,
   input  logic [APB_DATA_W-1:0] pwdata,
   output logic [APB_DATA_W-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   apb_state_e            state, state_nx;
   logic [3:0]            wait_cnt, wait_nx;
   logic                  pready_nx, pslverr_nx;
   logic [APB_DATA_W-1:0] prdata_nx;

   logic                  lat_write, lat_err;
   logic [7:0]            lat_idx;
   logic [APB_DATA_W-1:0] lat_wdata;
   logic                  latch;

   apb_dec_t              dec;
   logic                  ro_now, err_now;
   logic                  wr_en;
   logic [7:0]            rd_idx;
   logic [APB_DATA_W-1:0] rd_data;

   always_comb begin
      dec    = apb_decode(paddr, BASE_ADDR, NUM_REGS);
      ro_now = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (dec.idx == 8'(i)) ro_now = RO_MASK[i];
      end
      err_now = dec.addr_err | (pwrite & ~dec.addr_err & ro_now);
   end

   // Zero-wait reads are served straight from the live address in IDLE.
   assign rd_idx = (state == IDLE) ? dec.idx : lat_idx;

   apb_reg_bank #(
      .NUM_REGS  (NUM_REGS),
      .RESET_VAL (RESET_VAL)
   ) u_bank (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (wr_en),
      .wr_idx  (lat_idx),
      .wr_data (lat_wdata),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         prdata    <= '0;
         lat_write <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         pready   <= pready_nx;
         pslverr  <= pslverr_nx;
         prdata   <= prdata_nx;
         if (latch) begin
            lat_write <= pwrite;
            lat_err   <= err_now;
            lat_idx   <= dec.idx;
            lat_wdata <= pwdata;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      wait_nx    = wait_cnt;
      pready_nx  = pready;
      pslverr_nx = pslverr;
      prdata_nx  = prdata;
      latch      = 1'b0;
      wr_en      = 1'b0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               latch    = 1'b1;
               state_nx = ACCESS;
               wait_nx  = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  pready_nx  = 1'b1;
                  pslverr_nx = err_now;
                  prdata_nx  = (pwrite || err_now) ? '0 : rd_data;
               end
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_nx   = IDLE;
               wait_nx    = '0;
               pready_nx  = 1'b0;
               pslverr_nx = 1'b0;
               prdata_nx  = '0;
            end else if (pready) begin
               wr_en      = lat_write & ~lat_err;
               state_nx   = IDLE;
               pready_nx  = 1'b0;
               pslverr_nx = 1'b0;
               prdata_nx  = '0;
            end else if (wait_cnt == 4'd1) begin
               pready_nx  = 1'b1;
               pslverr_nx = lat_err;
               prdata_nx  = (lat_write || lat_err) ? '0 : rd_data;
               wait_nx    = '0;
            end else begin
               wait_nx = wait_cnt - 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: three completers with different wait/base/read-only setups,
// directed APB transfers followed by random traffic against an array model.
module tb_apb_slave_regfile;

   localparam int          ND = 3;
   localparam logic [31:0] RV = 32'hC0DE_0000;
   localparam int          WS   [ND] = '{0, 3, 2};
   localparam logic [31:0] BASE [ND] = '{32'h0, 32'h100, 32'h0};
   localparam logic [15:0] ROM  [ND] = '{16'h0000, 16'h8000, 16'h0001};

   logic        clk;
   logic        resetn  [ND];
   logic        psel    [ND];
   logic        penable [ND];
   logic [31:0] paddr   [ND];
   logic        pwrite  [ND];
   logic [31:0] pwdata  [ND];
   logic [31:0] prdata_o  [ND];
   logic        pready_o  [ND];
   logic        pslverr_o [ND];

   typedef struct {
      int          dut;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mem [ND][16];
   int          total = 0;
   int          bad   = 0;
   bit          mon_en = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(BASE[0]), .WAIT_STATES(WS[0]),
                       .RO_MASK(ROM[0]), .RESET_VAL(RV)) dut0 (
      .clk(clk), .resetn(resetn[0]), .psel(psel[0]), .penable(penable[0]),
      .paddr(paddr[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
      .prdata(prdata_o[0]), .pready(pready_o[0]), .pslverr(pslverr_o[0]));

   apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(BASE[1]), .WAIT_STATES(WS[1]),
                       .RO_MASK(ROM[1]), .RESET_VAL(RV)) dut1 (
      .clk(clk), .resetn(resetn[1]), .psel(psel[1]), .penable(penable[1]),
      .paddr(paddr[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
      .prdata(prdata_o[1]), .pready(pready_o[1]), .pslverr(pslverr_o[1]));

   apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(BASE[2]), .WAIT_STATES(WS[2]),
                       .RO_MASK(ROM[2]), .RESET_VAL(RV)) dut2 (
      .clk(clk), .resetn(resetn[2]), .psel(psel[2]), .penable(penable[2]),
      .paddr(paddr[2]), .pwrite(pwrite[2]), .pwdata(pwdata[2]),
      .prdata(prdata_o[2]), .pready(pready_o[2]), .pslverr(pslverr_o[2]));

   function automatic void check(input string name, input int d,
                                 input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
      end
   endfunction

   // Reference model: register file as a plain array, rules from the address map.
   function automatic void model(input int d, input logic [31:0] addr, input logic wr,
                                 input logic [31:0] wd, output logic [31:0] rdata,
                                 output logic err);
      int unsigned off, idx;
      off   = addr - BASE[d];
      err   = (addr % 4 != 0) || (addr < BASE[d]) || (off >= 64);
      rdata = '0;
      if (!err) begin
         idx = off / 4;
         if (wr && ROM[d][idx]) err = 1'b1;
         else if (wr) mem[d][idx] = wd;
         else rdata = mem[d][idx];
      end
   endfunction

   task automatic model_reset(input int d);
      for (int i = 0; i < 16; i++) mem[d][i] = RV;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < ND; d++) begin
            total++;
            if ($isunknown({prdata_o[d], pready_o[d], pslverr_o[d]})) begin
               bad++;
               $display("FAIL xz dut%0d: outputs %h %b %b", d, prdata_o[d], pready_o[d], pslverr_o[d]);
            end
            if (pready_o[d] === 1'b1) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL stray_pready dut%0d: got pready=1 expected no response", d);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("resp_dut", d, 32'(d), 32'(e.dut));
                  check("prdata", d, prdata_o[d], e.rdata);
                  check("pslverr", d, {31'd0, pslverr_o[d]}, {31'd0, e.err});
               end
            end
         end
      end
   end

   // Caller is at posedge+1; returns at posedge+1 after the completing edge.
   task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input bit idle_after);
      exp_t e;
      int   cyc;
      bit   seen;
      model(d, addr, wr, wd, e.rdata, e.err);
      e.dut = d;
      sb.push_back(e);
      psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = addr; pwrite[d] = wr; pwdata[d] = wd;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      paddr[d]   = $urandom;
      pwdata[d]  = $urandom;
      cyc  = 1;
      seen = 0;
      while (!seen && cyc < 32) begin
         cyc++;
         @(negedge clk);
         seen = (pready_o[d] === 1'b1);
         @(posedge clk); #1;
      end
      check("latency", d, 32'(cyc), 32'(2 + WS[d]));
      if (!seen && sb.size() > 0) void'(sb.pop_back());
      if (idle_after) begin
         psel[d] = 1'b0; penable[d] = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Starts a write, then kills it in the first wait cycle by psel drop or reset.
   task automatic abort_write(input int d, input logic [31:0] addr,
                              input logic [31:0] wd, input bit by_reset);
      psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = addr; pwrite[d] = 1'b1; pwdata[d] = wd;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      @(negedge clk);
      if (by_reset) resetn[d] = 1'b0;
      else begin psel[d] = 1'b0; penable[d] = 1'b0; end
      @(posedge clk); #1;
      resetn[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
      if (by_reset) begin
         model_reset(d);
         @(negedge clk);
         check("rst_prdata", d, prdata_o[d], 32'h0);
         check("rst_pready", d, {31'd0, pready_o[d]}, 32'h0);
         @(posedge clk); #1;
      end
      idle(6);
   endtask

   initial begin
      logic [31:0] a, w;
      int          r;
      for (int d = 0; d < ND; d++) begin
         resetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
         paddr[d] = '0; pwrite[d] = 1'b0; pwdata[d] = '0;
         model_reset(d);
      end
      @(posedge clk);
      mon_en = 1;
      @(posedge clk); @(posedge clk); #1;
      for (int d = 0; d < ND; d++) resetn[d] = 1'b1;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         check("reset_prdata", d, prdata_o[d], 32'h0);
         check("reset_pready", d, {31'd0, pready_o[d]}, 32'h0);
         check("reset_pslverr", d, {31'd0, pslverr_o[d]}, 32'h0);
      end
      @(posedge clk); #1;

      // zero-wait write/read and back-to-back
      xfer(0, 32'h08, 1'b1, 32'hDEAD_BEEF, 1); idle(1);
      xfer(0, 32'h08, 1'b0, 32'h0, 1); idle(2);
      for (int i = 0; i < 4; i++) xfer(0, 32'(4 * i), 1'b1, 32'h1111_0000 + 32'(i), 0);
      for (int i = 0; i < 4; i++) xfer(0, 32'(4 * i), 1'b0, 32'h0, (i == 3));
      idle(2);

      // three wait states, non-zero base
      xfer(1, 32'h104, 1'b0, 32'h0, 1); idle(1);
      xfer(1, 32'h0FC, 1'b0, 32'h0, 1);
      xfer(1, 32'h13C, 1'b1, 32'h7777_7777, 1);
      xfer(1, 32'h140, 1'b1, 32'h7777_7777, 1);
      xfer(1, 32'h13C, 1'b0, 32'h0, 1); idle(2);

      // errors, read-only, aborts
      xfer(2, 32'h40, 1'b0, 32'h0, 1);
      xfer(2, 32'h06, 1'b1, 32'hAAAA_AAAA, 1);
      xfer(2, 32'h00, 1'b1, 32'hBBBB_BBBB, 1);
      xfer(2, 32'h00, 1'b0, 32'h0, 1); idle(1);
      abort_write(2, 32'h10, 32'h1234, 0);
      xfer(2, 32'h10, 1'b0, 32'h0, 1);
      xfer(2, 32'h10, 1'b1, 32'h5555_5555, 1);
      abort_write(2, 32'h10, 32'h1234, 0);
      xfer(2, 32'h10, 1'b0, 32'h0, 1);
      abort_write(2, 32'h10, 32'h1234, 1);
      xfer(2, 32'h10, 1'b0, 32'h0, 1); idle(2);

      // random traffic
      for (int d = 0; d < ND; d++) begin
         for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE[d] + 32'(4 * $urandom_range(0, 15));
            else if (r == 7) a = BASE[d] + 32'($urandom_range(0, 63) & ~3) + 32'($urandom_range(1, 3));
            else if (r == 8) a = BASE[d] + 32'd64 + 32'(4 * $urandom_range(0, 15));
            else             a = (BASE[d] != 0) ? BASE[d] - 32'd4 : 32'h200;
            w = $urandom;
            r = $urandom_range(0, 2);
            xfer(d, a, 1'($urandom_range(0, 1)), w, (r != 0));
            if (r != 0) idle(r);
         end
         psel[d] = 1'b0; penable[d] = 1'b0;
         idle(2);
      end

      idle(4);
      check("sb_empty", 0, 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
